imem_loader: RTL and testbench

- Sequential boot loader that fills the word-addressed instruction memory from a byte-serial stream, such as a UART receive FIFO, before the CPU runs.
- Parses a 2-byte word-count header, then assembles big-endian 32-bit words and issues one write strobe per word at incrementing word addresses.
- Holds the CPU off while a load is in progress.
- Sits between the host byte source and the write port of the instruction memory.

---
 rtl/imem_pkg.sv | 19 +
 rtl/byte_packer.sv | 32 +++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader: sizing constants
// and the loader FSM state encoding.
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 256;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes MSB first into one big-endian 32-bit word.
// word_next presents the complete word while the fourth byte is on byte_in.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word_next
);

    logic [1:0]  lane;
    logic [23:0] sreg;

    // Only the three earlier bytes need storage; the last one is taken live.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= 2'd0;
            sreg <= 24'd0;
        end else if (clear) begin
            lane <= 2'd0;
        end else if (shift) begin
            lane <= lane + 2'd1;
            sreg <= word_next[23:0];
        end
    end

    assign word_full = (lane == 2'd3);
    assign word_next = {sreg, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 2-byte word count, then writes big-endian words into
// instruction memory. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t            state;
    state_t            state_nx;
    logic [15:0]       count;
    logic [15:0]       hdr_count;
    logic [ADDR_W-1:0] index;
    logic              xfer;
    logic              last_word;
    logic              start_ok;
    logic              word_full;
    logic [31:0]       word_next;

    assign xfer      = byte_valid && byte_ready;
    assign start_ok  = (state == IDLE) && start;
    assign hdr_count = {count[15:8], byte_data};
    assign last_word = (16'(index) == count - 16'd1);

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok || (state == WRITE)),
        .shift     ((state == DATA) && xfer),
        .byte_in   (byte_data),
        .word_full (word_full),
        .word_next (word_next)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xsum <= 8'd0;
        end else if (start_ok) begin
            xsum <= 8'd0;
        end else if (xfer && (state inside {HDR_HI, HDR_LO, DATA})) begin
            xsum <= xsum ^ byte_data;
        end
    end
`endif

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                if (xfer) state_nx = HDR_LO;
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    if (hdr_count == 16'd0)
                        state_nx = DONE;
                    else if ({1'b0, hdr_count} > DEPTH)
                        state_nx = ERR;
                    else
                        state_nx = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (xfer && word_full) state_nx = WRITE;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_nx = last_word ? CHK : DATA;
`else
                state_nx = last_word ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                if (xfer) state_nx = (byte_data == xsum) ? DONE : ERR;
            end
`endif
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write port is loaded as the fourth byte lands so it holds between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 16'd0;
            index     <= '0;
            err       <= 1'b0;
            cpu_hold  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= 32'd0;
        end else begin
            state    <= state_nx;
            cpu_hold <= (state_nx != IDLE);
            mem_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err   <= 1'b0;
                        index <= '0;
                    end
                end
                HDR_HI: begin
                    if (xfer) count[15:8] <= byte_data;
                end
                HDR_LO: begin
                    if (xfer) count <= hdr_count;
                end
                DATA: begin
                    if (xfer && word_full) begin
                        mem_we    <= 1'b1;
                        mem_waddr <= index;
                        mem_wdata <= word_next;
                    end
                end
                WRITE: begin
                    if (!last_word) index <= index + 1'b1;
                end
                ERR: err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads with a byte-stream
// reference model, random valid gaps, stray starts and a mid-load reset abort.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [15:0] count;
        int          mode;       // 0 random words, 1 word == index, 2 fixed words
        bit          gaps;       // random byte_valid and stray start pulses
        bit          badChk;
        int          abortAfter; // reset after this many writes (0 = never)
        bit          expDone;
        bit          expErr;
        int          expWrites;
    } vecT;

    vecT vecs[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " byte_ready"}, byte_ready, 0);
        checkOutput({tag, " mem_we"},     mem_we,     0);
        checkOutput({tag, " mem_waddr"},  mem_waddr,  0);
        checkOutput({tag, " mem_wdata"},  mem_wdata,  0);
        checkOutput({tag, " cpu_hold"},   cpu_hold,   0);
        checkOutput({tag, " busy"},       busy,       0);
        checkOutput({tag, " done"},       done,       0);
        checkOutput({tag, " err"},        err,        0);
    endtask

    // Runs one complete load; called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input vecT v);
        logic [7:0]  stream[$];
        logic [7:0]  expAddr[$];
        logic [31:0] expData[$];
        logic [7:0]  xsum;
        logic [31:0] w;
        logic [7:0]  lastAddr;
        logic [31:0] lastData;
        int          n;
        int          busyCycles;
        int          doneCount;
        int          writeCount;
        bit          xferNow;
        bit          aborted;

        n = int'(v.count);
        stream.push_back(v.count[15:8]);
        stream.push_back(v.count[7:0]);
        xsum = v.count[15:8] ^ v.count[7:0];
        if (n >= 1 && n <= 256) begin
            for (int i = 0; i < n; i++) begin
                case (v.mode)
                    1:       w = i;
                    2:       w = (i == 0) ? 32'h2005000A : 32'h0000_0000;
                    default: w = $urandom;
                endcase
                expAddr.push_back(i[7:0]);
                expData.push_back(w);
                for (int b = 3; b >= 0; b--) begin
                    stream.push_back(w[8*b +: 8]);
                    xsum ^= w[8*b +: 8];
                end
            end
            if (CHK_EN != 0) stream.push_back(v.badChk ? ~xsum : xsum);
        end

        lastAddr   = 8'h00;
        lastData   = 32'h0;
        busyCycles = 0;
        doneCount  = 0;
        writeCount = 0;
        xferNow    = 1'b0;
        aborted    = 1'b0;

        start      = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("err cleared by start", err, 0);
        checkOutput("busy after start", busy, 1);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!busy) break;
            busyCycles++;
            checkOutput("cpu_hold while busy", cpu_hold, 1);
            if (mem_we) begin
                writeCount++;
                checkOutput("byte_ready in WRITE", byte_ready, 0);
                checkOutput("write follows 4th byte", xferNow, 1);
                if (expAddr.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected write: actual addr %0h data %0h required none", mem_waddr, mem_wdata);
                end else begin
                    lastAddr = expAddr.pop_front();
                    lastData = expData.pop_front();
                    checkOutput("mem_waddr", mem_waddr, lastAddr);
                    checkOutput("mem_wdata", mem_wdata, lastData);
                end
                if (v.abortAfter != 0 && writeCount == v.abortAfter) begin
                    aborted = 1'b1;
                    #2 reset = 1'b1;
                    #1 checkAllZero("async abort");
                    @(posedge clk); #1;
                    checkAllZero("abort next edge");
                    @(negedge clk);
                    reset = 1'b0;
                    for (int k = 0; k < 20; k++) begin
                        byte_valid = 1'b1;
                        byte_data  = 8'hA5;
                        @(posedge clk); #1;
                        checkOutput("no write after abort", mem_we, 0);
                        checkOutput("idle after abort", busy, 0);
                    end
                    byte_valid = 1'b0;
                    break;
                end
            end
            if (done) begin
                doneCount++;
                checkOutput("done timing", xferNow, (n == 0 || CHK_EN != 0) ? 1 : 0);
            end
            start      = v.gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            byte_valid = (stream.size() > 0) && (!v.gaps || $urandom_range(0, 1) == 1);
            byte_data  = (stream.size() > 0) ? stream[0] : 8'h00;
            xferNow    = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (xferNow) void'(stream.pop_front());
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        if (aborted) begin
            checkOutput("writes before abort", writeCount, v.expWrites);
            return;
        end
        checkOutput("load finished in bound", busy, 0);
        checkOutput("cpu_hold after load", cpu_hold, 0);
        checkOutput("done pulses", doneCount, v.expDone ? 1 : 0);
        checkOutput("err flag", err, v.expErr ? 1 : 0);
        checkOutput("write count", writeCount, v.expWrites);
        checkOutput("writes outstanding", expAddr.size(), 0);
        if (writeCount > 0) begin
            checkOutput("mem_waddr holds", mem_waddr, lastAddr);
            checkOutput("mem_wdata holds", mem_wdata, lastData);
        end
        if (!v.gaps && v.expDone)
            checkOutput("load cycles", busyCycles, 3 + 5 * n + ((n > 0) ? CHK_EN : 0));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #1 checkAllZero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle after reset", busy, 0);

        //                count     mode gaps bad abort done err writes
        vecs.push_back('{16'h0002, 2, 1'b0, 1'b0, 0, 1'b1, 1'b0, 2});
        vecs.push_back('{16'h0000, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0});
        vecs.push_back('{16'h0101, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0});
        vecs.push_back('{16'h0001, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1});
        vecs.push_back('{16'h0003, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 3});
        vecs.push_back('{16'h0003, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 3});
        vecs.push_back('{16'h0100, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 256});
        vecs.push_back('{16'h1000, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0});
        vecs.push_back('{16'h0005, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 5});
        vecs.push_back('{16'h0004, 0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 2});
        vecs.push_back('{16'h0002, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back('{16'h0001, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1});
        vecs.push_back('{16'h0002, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2});
`endif

        foreach (vecs[i]) begin
            $display("[TB] vector %0d: count=%0d mode=%0d gaps=%0d", i, vecs[i].count, vecs[i].mode, vecs[i].gaps);
            applyStimulus(vecs[i]);
            repeat (2) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
